// File: rtl/linfit_dev_core_if.sv
// Bundle between linfit_dev_core, the sample buffer and the predictor FSM.
// LINFITDEV_MAXDEV_EN adds the maxdev/maxidx result signals.
interface linfit_dev_core_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 32
);
   logic [IDX_W-1:0]  si;
   logic [IDX_W-1:0]  ei;
   logic              start;
   logic [IDX_W-1:0]  index;
   logic [DATA_W-1:0] value;
   logic [DATA_W-1:0] mean;
   logic [DATA_W-1:0] deviation;
   logic              busy;
   logic              done;
   logic              err;
`ifdef LINFITDEV_MAXDEV_EN
   logic [DATA_W-1:0] maxdev;
   logic [IDX_W-1:0]  maxidx;
`endif

   modport slave (
      input  si, ei, start, value,
`ifdef LINFITDEV_MAXDEV_EN
      output maxdev, maxidx,
`endif
      output index, mean, deviation, busy, done, err
   );

   modport master (
      output si, ei, start, value,
`ifdef LINFITDEV_MAXDEV_EN
      input  maxdev, maxidx,
`endif
      input  index, mean, deviation, busy, done, err
   );
endinterface

// File: rtl/linfit_dev_core.sv
// Two-pass window mean / mean-absolute-deviation engine.
// LINFITDEV_MAXDEV_EN builds the max |y-mean| tracker.
module linfit_dev_core #(
   parameter int DATA_W = 32,
   parameter int IDX_W  = 32,
   parameter int ACC_W  = DATA_W + IDX_W,
   parameter int RD_LAT = 1
) (
   input  logic             Clk,
   input  logic             Rst,
   linfit_dev_core_if.slave bus
);
   localparam int CW_A = $clog2(ACC_W) + 1;
   localparam int CW = (CW_A > IDX_W + 1) ? CW_A : IDX_W + 1;
   localparam logic [CW-1:0] LAT = CW'(RD_LAT);
   localparam logic [CW-1:0] DIV_LAST = CW'(ACC_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SUM, S_DIV1, S_DEV, S_DIV2, S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  si_q, si_d;
   logic [IDX_W-1:0]  n_q, n_d;
   logic [IDX_W-1:0]  index_q, index_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W-1:0]  rem_q, rem_d;
   logic [DATA_W-1:0] avg_q, avg_d;
   logic [DATA_W-1:0] mean_q, mean_d;
   logic [DATA_W-1:0] dev_q, dev_d;
   logic              err_q, err_d;

   logic [CW-1:0]     span;
   logic              rd_ok, issue_more, pass_last, div_last;
   logic              bad_win, fin_ok, fin_err;
   logic [DATA_W-1:0] absd;
   logic [ACC_W:0]    rem_sh;
   logic [ACC_W:0]    dvs;
   logic [ACC_W-1:0]  rem_nx, quo_nx;

   assign span       = CW'(n_q) + LAT;
   assign rd_ok      = cnt_q >= LAT;
   assign issue_more = (cnt_q + CW'(1)) < CW'(n_q);
   assign pass_last  = cnt_q == span - CW'(1);
   assign div_last   = cnt_q == DIV_LAST;
   assign bad_win    = bus.ei <= bus.si;
   assign fin_err    = (state_q == S_IDLE) && bus.start && bad_win;
   assign fin_ok     = (state_q == S_DIV2) && div_last;
   assign absd       = (bus.value > avg_q) ? bus.value - avg_q
                                           : avg_q - bus.value;

   // Restoring divide step: dividend shifts out of acc, quotient shifts in.
   always_comb begin
      dvs    = {1'b0, ACC_W'(n_q)};
      rem_sh = {rem_q, acc_q[ACC_W-1]};
      rem_nx = rem_sh[ACC_W-1:0];
      quo_nx = {acc_q[ACC_W-2:0], 1'b0};
      if (rem_sh >= dvs) begin
         rem_nx = ACC_W'(rem_sh - dvs);
         quo_nx = {acc_q[ACC_W-2:0], 1'b1};
      end
   end

   always_comb begin
      state_d = state_q;
      si_d    = si_q;
      n_d     = n_q;
      index_d = index_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      avg_d   = avg_q;
      mean_d  = mean_q;
      dev_d   = dev_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               si_d  = bus.si;
               n_d   = bus.ei - bus.si;
               cnt_d = '0;
               acc_d = '0;
               rem_d = '0;
               if (bad_win) begin
                  state_d = S_FIN;
                  err_d   = 1'b1;
                  mean_d  = '0;
                  dev_d   = '0;
               end else begin
                  state_d = S_SUM;
                  index_d = bus.si;
               end
            end
         end
         S_SUM, S_DEV: begin
            cnt_d = cnt_q + CW'(1);
            if (issue_more) index_d = index_q + IDX_W'(1);
            if (rd_ok) begin
               if (state_q == S_SUM)
                  acc_d = acc_q + ACC_W'(bus.value);
               else
                  acc_d = acc_q + ACC_W'(absd);
            end
            if (pass_last) begin
               cnt_d   = '0;
               state_d = (state_q == S_SUM) ? S_DIV1 : S_DIV2;
            end
         end
         S_DIV1, S_DIV2: begin
            acc_d = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + CW'(1);
            if (div_last) begin
               cnt_d = '0;
               acc_d = '0;
               rem_d = '0;
               if (state_q == S_DIV1) begin
                  avg_d   = quo_nx[DATA_W-1:0];
                  index_d = si_q;
                  state_d = S_DEV;
               end else begin
                  mean_d  = avg_q;
                  dev_d   = quo_nx[DATA_W-1:0];
                  err_d   = 1'b0;
                  state_d = S_FIN;
               end
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         si_q    <= '0;
         n_q     <= '0;
         index_q <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         avg_q   <= '0;
         mean_q  <= '0;
         dev_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         si_q    <= si_d;
         n_q     <= n_d;
         index_q <= index_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         avg_q   <= avg_d;
         mean_q  <= mean_d;
         dev_q   <= dev_d;
         err_q   <= err_d;
      end
   end

   assign bus.index     = index_q;
   assign bus.mean      = mean_q;
   assign bus.deviation = dev_q;
   assign bus.err       = err_q;
   assign bus.done      = state_q == S_FIN;
   assign bus.busy      = (state_q != S_IDLE) && (state_q != S_FIN);

`ifdef LINFITDEV_MAXDEV_EN
   logic [DATA_W-1:0] mx_q, mx_d, maxdev_q, maxdev_d;
   logic [IDX_W-1:0]  mi_q, mi_d, maxidx_q, maxidx_d;

   // First sample of the pass always loads, so ties keep the earliest index.
   always_comb begin
      mx_d     = mx_q;
      mi_d     = mi_q;
      maxdev_d = maxdev_q;
      maxidx_d = maxidx_q;
      if (state_q == S_DEV && rd_ok &&
          (cnt_q == LAT || absd > mx_q)) begin
         mx_d = absd;
         mi_d = si_q + IDX_W'(cnt_q - LAT);
      end
      if (fin_err) begin
         maxdev_d = '0;
         maxidx_d = '0;
      end else if (fin_ok) begin
         maxdev_d = mx_q;
         maxidx_d = mi_q;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         mx_q     <= '0;
         mi_q     <= '0;
         maxdev_q <= '0;
         maxidx_q <= '0;
      end else begin
         mx_q     <= mx_d;
         mi_q     <= mi_d;
         maxdev_q <= maxdev_d;
         maxidx_q <= maxidx_d;
      end
   end

   assign bus.maxdev = maxdev_q;
   assign bus.maxidx = maxidx_q;
`else
   logic unused_fin;
   assign unused_fin = fin_ok ^ fin_err;
`endif
endmodule

// File: tb/tb_linfit_dev_core.sv
// Scoreboard bench for linfit_dev_core: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_linfit_dev_core;
   localparam int DATA_W = 32;
   localparam int IDX_W  = 32;
   localparam int ACC_W  = 64;
   localparam int RD_LAT = 1;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   always #5 Clk = ~Clk;

   linfit_dev_core_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

   linfit_dev_core #(
      .DATA_W(DATA_W), .IDX_W(IDX_W), .ACC_W(ACC_W), .RD_LAT(RD_LAT)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus)
   );

   // Sample buffer: one-cycle registered read.
   logic [31:0] mem [64];
   logic [31:0] rd_q;
   always @(posedge Clk)
      rd_q <= (bus.index < 64) ? mem[bus.index[5:0]] : 32'd0;
   assign bus.value = rd_q;

   typedef struct {
      longint unsigned mean;
      longint unsigned dev;
      longint unsigned mx;
      longint unsigned mi;
      bit              err;
      longint          done_cyc;
      string           tag;
   } exp_t;

   exp_t   q[$];
   int     tests = 0;
   int     fails = 0;
   longint cyc = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic void chk(string name, longint unsigned act,
                               longint unsigned want);
      tests++;
      if (act != want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, want);
      end
   endfunction

   function automatic exp_t mk(string tag, longint unsigned m,
                               longint unsigned d, longint unsigned mx,
                               longint unsigned mi, bit err);
      exp_t e;
      e.tag = tag; e.mean = m; e.dev = d;
      e.mx = mx; e.mi = mi; e.err = err; e.done_cyc = 0;
      return e;
   endfunction

   // Reference: plain arithmetic over the window contents.
   function automatic exp_t model(string tag, int si, int ei);
      exp_t e;
      longint unsigned s, d, m, a;
      int n;
      e = mk(tag, 0, 0, 0, 0, 1'b1);
      if (ei <= si) return e;
      n = ei - si;
      s = 0;
      for (int i = si; i < ei; i++) s += mem[i];
      m = s / n;
      d = 0;
      e.err = 1'b0;
      e.mi = si;
      for (int i = si; i < ei; i++) begin
         a = (mem[i] > m) ? mem[i] - m : m - mem[i];
         d += a;
         if (a > e.mx) begin
            e.mx = a;
            e.mi = i;
         end
      end
      e.mean = m;
      e.dev = d / n;
      return e;
   endfunction

   task automatic issue(int si, int ei, exp_t e, bit push);
      longint k;
      @(negedge Clk);
      bus.si = si;
      bus.ei = ei;
      bus.start = 1'b1;
      k = cyc + 1;
      // done is seen after edge k + 2(n+RD_LAT) + 2*ACC_W, or right after k
      if (ei > si) e.done_cyc = k + 2 * ((ei - si) + RD_LAT) + 2 * ACC_W;
      else e.done_cyc = k;
      if (push) q.push_back(e);
      @(negedge Clk);
      bus.start = 1'b0;
      if (push) begin
         chk({e.tag, " busy@k+1"}, bus.busy, (ei > si) ? 1 : 0);
         if (ei > si) chk({e.tag, " index@k+1"}, bus.index, si);
      end
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while (q.size() != 0 && i < 3000) begin
         @(negedge Clk);
         i++;
      end
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: %0d results pending, required 0", q.size());
         q.delete();
      end
      @(negedge Clk);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, " index"}, bus.index, 0);
      chk({tag, " mean"}, bus.mean, 0);
      chk({tag, " deviation"}, bus.deviation, 0);
      chk({tag, " busy"}, bus.busy, 0);
      chk({tag, " done"}, bus.done, 0);
      chk({tag, " err"}, bus.err, 0);
   endtask

   always @(negedge Clk) begin
      if (Rst && bus.done) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected done: got done=1 required 0 at %0d",
                     cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, " mean"}, bus.mean, e.mean);
            chk({e.tag, " deviation"}, bus.deviation, e.dev);
            chk({e.tag, " err"}, bus.err, e.err);
            chk({e.tag, " done cycle"}, cyc, e.done_cyc);
            chk({e.tag, " busy@done"}, bus.busy, 0);
`ifdef LINFITDEV_MAXDEV_EN
            chk({e.tag, " maxdev"}, bus.maxdev, e.mx);
            chk({e.tag, " maxidx"}, bus.maxidx, e.mi);
`endif
         end
      end
   end

   initial begin
      int pool[10];
      int si, ei, b;
      pool = '{33, 23, 15, 12, 82, 64, 53, 58, 66, 39};
      bus.start = 1'b0;
      bus.si = '0;
      bus.ei = '0;
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      for (int i = 0; i < 10; i++) mem[i] = pool[i];
      for (int i = 40; i < 56; i++) mem[i] = 32'hFFFF_FFFF;

      repeat (3) @(negedge Clk);
      chk_zero("reset");
      Rst = 1'b1;

      issue(0, 10, mk("plan", 44, 20, 38, 4, 0), 1);
      wait_idle();
      issue(3, 4, mk("single", 12, 0, 0, 3, 0), 1);
      wait_idle();
      issue(5, 5, mk("empty", 0, 0, 0, 0, 1), 1);
      wait_idle();
      issue(7, 2, mk("inverted", 0, 0, 0, 0, 1), 1);
      wait_idle();
      issue(40, 56, mk("allmax", 32'hFFFF_FFFF, 0, 0, 40, 0), 1);
      wait_idle();

      issue(0, 10, mk("midstart", 44, 20, 38, 4, 0), 1);
      repeat (3) @(negedge Clk);
      bus.si = 20;
      bus.ei = 30;
      bus.start = 1'b1;
      @(negedge Clk);
      bus.start = 1'b0;
      wait_idle();

      // start during the done cycle must be dropped
      issue(3, 4, mk("donestart", 12, 0, 0, 3, 0), 1);
      b = 0;
      while (!bus.done && b < 500) begin
         @(negedge Clk);
         b++;
      end
      bus.si = 9;
      bus.ei = 1;
      bus.start = 1'b1;
      @(negedge Clk);
      bus.start = 1'b0;
      wait_idle();
      repeat (3) @(negedge Clk);

      issue(0, 10, mk("aborted", 44, 20, 38, 4, 0), 1);
      repeat (80) @(negedge Clk);
      Rst = 1'b0;
      void'(q.pop_back());
      repeat (2) @(negedge Clk);
      chk_zero("midreset");
      Rst = 1'b1;
      issue(12, 30, model("postreset", 12, 30), 1);
      wait_idle();

      for (int t = 0; t < 12; t++) begin
         si = $urandom_range(0, 50);
         if ($urandom_range(0, 4) == 0) ei = $urandom_range(0, si);
         else ei = si + 1 + $urandom_range(0, 13);
         issue(si, ei, model($sformatf("rand%0d", t), si, ei), 1);
         wait_idle();
      end

      repeat (5) @(negedge Clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
